// File: rtl/io_console_pkg.sv
// Shared types and constants for the console I/O responder.
package io_console_pkg;

  localparam int unsigned DATA_W                = 32;
  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 50000;
  localparam int unsigned DEF_PRINT_HOLD_CYCLES = 0;

  typedef enum logic [2:0] {
    StIdle,
    StPrintHold,
    StWaitPress,
    StWaitRelease,
    StRelease
  } io_state_t;

endpackage

// File: rtl/io_button_debouncer.sv
// Two-flop synchronizer plus stable-level counter for a bouncing push-button.
module io_button_debouncer
  import io_console_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1 before the level flips.
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q;

  // Synchronize, then flip the level after enough consecutive differing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (sync_q[1] != level_q) begin
        if (cnt_q == CntMax) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        // Any sample agreeing with the current level restarts the run.
        cnt_q <= '0;
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/io_console_unit.sv
// Console I/O responder: latches print values, stalls the core for switch input.
module io_console_unit
  import io_console_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned PRINT_HOLD_CYCLES = DEF_PRINT_HOLD_CYCLES,
  parameter int unsigned SW_WIDTH          = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                print,
  input  logic [DATA_W-1:0]   print_data,
  input  logic                in_req,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic                enter_btn,
  output logic                pause,
  output logic                read,
  output logic [DATA_W-1:0]   in_data,
  output logic [DATA_W-1:0]   display_value,
  output logic                display_valid,
  output logic                busy
);

  // Hold counter loads HOLD-1 so PRINT_HOLD lasts exactly HOLD cycles.
  localparam int unsigned HoldW = (PRINT_HOLD_CYCLES > 1) ? $clog2(PRINT_HOLD_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(PRINT_HOLD_CYCLES - 1);
  localparam logic HoldEn = (PRINT_HOLD_CYCLES > 0);

  io_state_t         state_q;
  logic [HoldW-1:0]  hold_q;
  logic              in_flag_q;
  logic              armed_q;
  logic [DATA_W-1:0] in_data_q;
  logic [DATA_W-1:0] disp_q;
  logic              valid_q;
  logic              btn_level;

  io_button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk  (clk),
    .reset(reset),
    .raw  (enter_btn),
    .level(btn_level)
  );

  // Control FSM with hold counter and capture registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      hold_q    <= '0;
      in_flag_q <= 1'b0;
      armed_q   <= 1'b0;
      in_data_q <= '0;
      disp_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_req) begin
            state_q   <= StWaitPress;
            in_flag_q <= 1'b0;
            armed_q   <= 1'b0;
          end else if (print) begin
            disp_q  <= print_data;
            valid_q <= 1'b1;
            if (HoldEn) begin
              hold_q  <= HoldLoad;
              state_q <= StPrintHold;
            end
          end
        end
        StPrintHold: begin
          if (hold_q == '0) begin
            state_q   <= StRelease;
            in_flag_q <= 1'b0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        StWaitPress: begin
          // A button already held on entry must be seen low before it counts.
          if (!btn_level) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            in_data_q <= DATA_W'(switches);
            in_flag_q <= 1'b1;
            state_q   <= StWaitRelease;
          end
        end
        StWaitRelease: begin
          if (!btn_level) state_q <= StRelease;
        end
        StRelease: begin
          // Old instruction is still current here; requests are ignored.
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Mealy stall so the PC never moves past a requesting instruction.
  always_comb begin
    pause = 1'b0;
    unique case (state_q)
      StPrintHold, StWaitPress, StWaitRelease: pause = 1'b1;
      StIdle:                                  pause = in_req | (print & HoldEn);
      default:                                 pause = 1'b0;
    endcase
    pause = pause & reset;
    read  = reset & (state_q == StRelease) & in_flag_q;
  end

  assign in_data       = in_data_q;
  assign display_value = disp_q;
  assign display_valid = valid_q;
  assign busy          = (state_q != StIdle);

endmodule
